keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad: drives one row low at a time, samples the four

---
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, samples the synchronized columns
// once per row slot, debounces press/release and emits one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned   TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cap_code_q, cap_code_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_s_q, col_s_d;

  logic       tick;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       col_valid;
  logic [3:0] cnt_inc;
  logic [3:0] row_next;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    col_meta_d = col;
    col_s_d    = col_meta_q;
    cnt_inc    = cnt_q + 4'd1;
    row_next   = {row_q[2:0], row_q[3]};

    case (row_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase

    // Only a single low column is a key; multiple lows are ghosting/chords and ignored.
    col_valid = 1'b1;
    case (col_s_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: begin
        col_idx   = 2'd0;
        col_valid = 1'b0;
      end
    endcase

    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    cap_code_d  = cap_code_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_valid) begin
            cap_code_d = {row_idx, col_idx};
            if (DB_LAST == 4'd1) begin
              key_code_d  = {row_idx, col_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_next;
          end
        end
        DEBOUNCE: begin
          if (col_valid && (col_idx == cap_code_q[1:0])) begin
            if (cnt_inc == DB_LAST) begin
              key_code_d  = cap_code_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = SCAN;
            row_d   = row_next;
          end
        end
        HELD: begin
          // Other columns are ignored here: no rollover while a key is held.
          if (!col_s_q[cap_code_q[1:0]]) begin
            cnt_d = 4'd0;
          end else if (cnt_inc == DB_LAST) begin
            key_held_d = 1'b0;
            cnt_d      = 4'd0;
            state_d    = SCAN;
            row_d      = row_next;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      tick_cnt_q  <= '0;
      row_q       <= 4'b1110;
      cnt_q       <= 4'd0;
      cap_code_q  <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_meta_q  <= 4'b1111;
      col_s_q     <= 4'b1111;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      cap_code_q  <= cap_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col from row and a pressed-key mask;
// accepted presses are checked against a queue of expected key codes.
module tb_keypad_scanner;

  localparam int ST = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Matrix model: a pressed switch shorts its column to its row when that row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) obs_q.push_back(key_code);

  function automatic logic [3:0] row_for(int i);
    case (i % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (row !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: row=%b valid=%b held=%b code=%b, expected 1110/0/0/0000",
               row, key_valid, key_held, key_code);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n_cmp++;
      if (row !== row_for(k / ST)) begin
        n_fail++;
        $display("FAIL idle_rotation cycle %0d: row=%b, expected %b", k, row, row_for(k / ST));
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_valid: got %0d pulses, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_press();
    logic [3:0] e, o;
    logic frozen;
    exp_q.push_back(4'b1001);
    pressed[9] = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL press_pulse_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL press_code: got %b, expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (key_held !== 1'b1 || key_code !== 4'b1001 || row !== 4'b1011) begin
      n_fail++;
      $display("FAIL press_state: held=%b code=%b row=%b, expected 1/1001/1011", key_held, key_code, row);
    end
    frozen = 1'b1;
    repeat (40) begin @(negedge clk); if (row !== 4'b1011) frozen = 1'b0; end
    n_cmp++;
    if (frozen !== 1'b1) begin n_fail++; $display("FAIL press_row_frozen: row=%b, expected 1011", row); end
  endtask

  task automatic test_release_repress();
    logic [3:0] e, o, r0;
    pressed[9] = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (key_held !== 1'b0 || key_code !== 4'b1001 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL release_state: held=%b code=%b pulses=%0d, expected 0/1001/0", key_held, key_code, obs_q.size());
    end
    r0 = row;
    repeat (16) @(negedge clk);
    n_cmp++;
    if (row === r0) begin n_fail++; $display("FAIL release_rotation: row=%b stuck, expected change", row); end
    exp_q.push_back(4'b1001);
    pressed[9] = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL repress_pulse_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL repress_code: got %b, expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pressed[9] = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL repress_release: held=%b, expected 0", key_held); end
  endtask

  task automatic test_other_keys();
    int keys[4] = '{0, 6, 15, 3};
    logic [3:0] e, o;
    foreach (keys[i]) begin
      exp_q.push_back(4'(keys[i]));
      pressed[keys[i]] = 1'b1;
      repeat (120) @(negedge clk);
      n_cmp++;
      if (key_held !== 1'b1) begin n_fail++; $display("FAIL keys_held key %0d: held=%b, expected 1", keys[i], key_held); end
      pressed[keys[i]] = 1'b0;
      repeat (60) @(negedge clk);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL keys_pulse_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL keys_code: got %b, expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bounce();
    int guard = 0;
    while (row === 4'b1101 && guard < 100) begin @(negedge clk); guard++; end
    while (row !== 4'b1101 && guard < 100) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 100) begin n_fail++; $display("FAIL bounce_wait_row: row=%b, expected 1101 within 100 cycles", row); end
    pressed[6] = 1'b1;
    repeat (16) @(negedge clk);
    pressed[6] = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (row !== 4'b1011) begin n_fail++; $display("FAIL bounce_resume: row=%b, expected 1011", row); end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || key_held !== 1'b0 || key_code !== 4'b0011) begin
      n_fail++;
      $display("FAIL bounce_no_accept: pulses=%0d held=%b code=%b, expected 0/0/0011", obs_q.size(), key_held, key_code);
    end
    obs_q.delete();
  endtask

  task automatic test_two_cols();
    int changes = 0;
    logic [3:0] prev;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    prev = row;
    repeat (100) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
    end
    n_cmp++;
    if (changes < 11) begin n_fail++; $display("FAIL two_cols_rotation: %0d row changes, expected >= 11", changes); end
    n_cmp++;
    if (obs_q.size() != 0 || key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL two_cols_no_accept: pulses=%0d held=%b, expected 0/0", obs_q.size(), key_held);
    end
    obs_q.delete();
    pressed = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_while_held();
    logic [3:0] e, o;
    exp_q.push_back(4'd12);
    pressed[12] = 1'b1;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (key_held !== 1'b1 || key_code !== 4'd12) begin
      n_fail++;
      $display("FAIL rst_pre_held: held=%b code=%b, expected 1/1100", key_held, key_code);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (row !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: row=%b held=%b code=%b valid=%b, expected 1110/0/0000/0",
               row, key_held, key_code, key_valid);
    end
    exp_q.push_back(4'd12);
    repeat (200) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_pulse_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rst_code: got %b, expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL rst_reheld: held=%b, expected 1", key_held); end
    pressed = '0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pressed = '0;
    test_reset();
    test_press();
    test_release_repress();
    test_other_keys();
    test_bounce();
    test_two_cols();
    test_reset_while_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
